// File: rtl/cache_axi_arbiter_pkg.sv
// Shared definitions for the cache-to-AXI arbiter.
// This file holds the FSM state encoding, the AXI burst and response codes,
// and the beat-size code that the caches use for a full-word beat.
package cache_axi_arbiter_pkg;

  // FSM state encoding. Kept as plain constants so that older code which
  // compares raw 3-bit state values still works.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_I_AR = 3'd1;
  localparam logic [2:0] ST_I_R  = 3'd2;
  localparam logic [2:0] ST_D_AR = 3'd3;
  localparam logic [2:0] ST_D_R  = 3'd4;
  localparam logic [2:0] ST_D_AW = 3'd5;
  localparam logic [2:0] ST_D_W  = 3'd6;
  localparam logic [2:0] ST_D_B  = 3'd7;

  // AXI encodings.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Size code for a 4-byte beat.
  localparam logic [2:0] SIZE_WORD = 3'h2;

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// AXI4 master bus of the cache arbiter, bundled as one interface.
// The "master" modport is the arbiter side.
// The "slave" modport is the main-memory side.
interface cache_axi_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  // write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_axi_arbiter_beat_counter.sv
// Write-burst beat counter for the cache arbiter.
// The counter is cleared when a write-back is granted and advances once per
// accepted W beat.
// "last" is high while the beat being offered is the final beat of the burst,
// that is, when the count equals the latched AXI length.
module cache_axi_arbiter_beat_counter (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       last
);

  logic [7:0] count_q;

  // clear on grant, count accepted beats otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= 8'd0;
    end else if (inc) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign last = (count_q == len);

endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter
// Merges three kinds of request onto one AXI4 master port:
//   - icache refill reads
//   - dcache refill reads
//   - dcache write-backs
// Only one burst is in flight at a time, and a burst is never preempted.
// A write-back wins over a dcache refill so that a dirty line reaches memory
// before the refill of the same line can be read back. Both dcache requests
// win over the icache.
// Read beats are passed combinationally to whichever cache owns the grant.
// Optional build macro: ARB_PERF_CNT_EN adds 64-bit grant and wait counters.
// These counters are visible through the hierarchy only.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    i_rvalid,
  output logic                    i_rready,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  input  logic [2:0]              i_rsize,
  input  logic [7:0]              i_rlen,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_rlast,

  input  logic                    d_rvalid,
  output logic                    d_rready,
  input  logic [ADDR_WIDTH-1:0]   d_raddr,
  input  logic [2:0]              d_rsize,
  input  logic [7:0]              d_rlen,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_rlast,

  input  logic                    d_wvalid,
  input  logic [ADDR_WIDTH-1:0]   d_waddr,
  input  logic [2:0]              d_wsize,
  input  logic [7:0]              d_wlen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_wready,
  output logic                    d_bvalid,

  cache_axi_arbiter_if.master     axi
);

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;

  logic grant_w;
  logic grant_dr;
  logic grant_i;
  logic w_fire;
  logic r_fire_last;
  logic beat_last;

  // Grant decode. The priority order is fixed: write-back, then dcache read,
  // then icache read.
  assign grant_w     = (state_q == ST_IDLE) && d_wvalid;
  assign grant_dr    = (state_q == ST_IDLE) && !d_wvalid && d_rvalid;
  assign grant_i     = (state_q == ST_IDLE) && !d_wvalid && !d_rvalid && i_rvalid;

  assign w_fire      = axi.wvalid && axi.wready;
  assign r_fire_last = axi.rvalid && axi.rlast;

  // next-state logic for the single-burst FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_w) begin
          state_d = ST_D_AW;
        end else if (grant_dr) begin
          state_d = ST_D_AR;
        end else if (grant_i) begin
          state_d = ST_I_AR;
        end
      end
      ST_I_AR: if (axi.arready)          state_d = ST_I_R;
      ST_I_R:  if (r_fire_last)          state_d = ST_IDLE;
      ST_D_AR: if (axi.arready)          state_d = ST_D_R;
      ST_D_R:  if (r_fire_last)          state_d = ST_IDLE;
      ST_D_AW: if (axi.awready)          state_d = ST_D_W;
      ST_D_W:  if (w_fire && beat_last)  state_d = ST_D_B;
      ST_D_B:  if (axi.bvalid)           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // state register; reset returns to IDLE, which drops every valid and ready
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // capture the winner's burst descriptor at grant; request ports are ignored afterwards
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      len_q  <= 8'd0;
      size_q <= 3'd0;
    end else if (grant_w) begin
      addr_q <= d_waddr;
      len_q  <= d_wlen;
      size_q <= d_wsize;
    end else if (grant_dr) begin
      addr_q <= d_raddr;
      len_q  <= d_rlen;
      size_q <= d_rsize;
    end else if (grant_i) begin
      addr_q <= i_raddr;
      len_q  <= i_rlen;
      size_q <= i_rsize;
    end
  end

  cache_axi_arbiter_beat_counter u_beat_counter (
    .clk  (clk),
    .rstn (rstn),
    .load (grant_w),
    .inc  (w_fire),
    .len  (len_q),
    .last (beat_last)
  );

  // AR and AW channels both carry the latched descriptor.
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (state_q == ST_I_AR) || (state_q == ST_D_AR);

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = (state_q == ST_D_AW);

  // Read data passes straight through to the grant owner.
  // There is no buffering, so the arbiter adds no latency to a read beat.
  assign axi.rready  = (state_q == ST_I_R) || (state_q == ST_D_R);
  assign i_rready    = (state_q == ST_I_R) && axi.rvalid;
  assign i_rlast     = i_rready && axi.rlast;
  assign i_rdata     = axi.rdata;
  assign d_rready    = (state_q == ST_D_R) && axi.rvalid;
  assign d_rlast     = d_rready && axi.rlast;
  assign d_rdata     = axi.rdata;

  // Write beats come directly from the dcache.
  // wlast comes from the beat counter.
  assign axi.wvalid  = (state_q == ST_D_W) && d_wvalid;
  assign axi.wdata   = d_wdata;
  assign axi.wstrb   = d_wstrb;
  assign axi.wlast   = (state_q == ST_D_W) && beat_last;
  assign d_wready    = (state_q == ST_D_W) && axi.wready;

  // The B response produces a one-cycle pulse to the dcache.
  // The FSM leaves D_B on the same handshake.
  assign axi.bready  = (state_q == ST_D_B);
  assign d_bvalid    = (state_q == ST_D_B) && axi.bvalid;

`ifdef ARB_PERF_CNT_EN
  logic [63:0] i_grant_cnt;
  logic [63:0] d_rgrant_cnt;
  logic [63:0] d_wgrant_cnt;
  logic [63:0] wait_cnt;
  logic        i_waiting;

  // The icache counts as waiting in IDLE and in every dcache state.
  assign i_waiting = i_rvalid &&
                     ((state_q == ST_IDLE) || (state_q == ST_D_AR) ||
                      (state_q == ST_D_R)  || (state_q == ST_D_AW) ||
                      (state_q == ST_D_W)  || (state_q == ST_D_B));

  // grant and icache-wait statistics
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_grant_cnt  <= 64'd0;
      d_rgrant_cnt <= 64'd0;
      d_wgrant_cnt <= 64'd0;
      wait_cnt     <= 64'd0;
    end else begin
      if (grant_i)   i_grant_cnt  <= i_grant_cnt + 64'd1;
      if (grant_dr)  d_rgrant_cnt <= d_rgrant_cnt + 64'd1;
      if (grant_w)   d_wgrant_cnt <= d_wgrant_cnt + 64'd1;
      if (i_waiting) wait_cnt     <= wait_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed self-checking bench for cache_axi_arbiter.
// A small AXI memory model answers bursts, and its backpressure can be
// switched on and off.
// When the bench is built with ARB_PERF_CNT_EN, it also checks the counters.
module tb_cache_axi_arbiter;
  import cache_axi_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        i_rvalid = 1'b0;
  logic        i_rready;
  logic [31:0] i_raddr = '0;
  logic [2:0]  i_rsize = '0;
  logic [7:0]  i_rlen = '0;
  logic [31:0] i_rdata;
  logic        i_rlast;

  logic        d_rvalid = 1'b0;
  logic        d_rready;
  logic [31:0] d_raddr = '0;
  logic [2:0]  d_rsize = '0;
  logic [7:0]  d_rlen = '0;
  logic [31:0] d_rdata;
  logic        d_rlast;

  logic        d_wvalid = 1'b0;
  logic [31:0] d_waddr = '0;
  logic [2:0]  d_wsize = '0;
  logic [7:0]  d_wlen = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_wready;
  logic        d_bvalid;

  int errors = 0;
  int checks = 0;

  cache_axi_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  cache_axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_rvalid (i_rvalid),
    .i_rready (i_rready),
    .i_raddr  (i_raddr),
    .i_rsize  (i_rsize),
    .i_rlen   (i_rlen),
    .i_rdata  (i_rdata),
    .i_rlast  (i_rlast),
    .d_rvalid (d_rvalid),
    .d_rready (d_rready),
    .d_raddr  (d_raddr),
    .d_rsize  (d_rsize),
    .d_rlen   (d_rlen),
    .d_rdata  (d_rdata),
    .d_rlast  (d_rlast),
    .d_wvalid (d_wvalid),
    .d_waddr  (d_waddr),
    .d_wsize  (d_wsize),
    .d_wlen   (d_wlen),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_wready (d_wready),
    .d_bvalid (d_bvalid),
    .axi      (axi)
  );

  always #5 clk = ~clk;

  // Memory-model controls, driven by the directed sequence.
  logic        arready_ctl = 1'b1;
  logic        r_gap = 1'b0;
  logic        w_gap = 1'b0;
  logic [1:0]  resp_val = AXI_RESP_OKAY;

  logic        r_active;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_tog;
  logic        w_tog;
  logic        b_pend;

  // The read beat k of a burst returns the data (burst address + 4*k).
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_tog    <= 1'b0;
      w_tog    <= 1'b0;
      b_pend   <= 1'b0;
    end else begin
      r_tog <= ~r_tog;
      w_tog <= ~w_tog;
      if (axi.arvalid && axi.arready) begin
        r_active <= 1'b1;
        r_addr   <= axi.araddr;
        r_len    <= axi.arlen;
        r_cnt    <= '0;
      end else if (axi.rvalid && axi.rready) begin
        r_cnt <= r_cnt + 8'd1;
        if (axi.rlast) r_active <= 1'b0;
      end
      if (axi.wvalid && axi.wready && axi.wlast) b_pend <= 1'b1;
      else if (axi.bvalid && axi.bready)         b_pend <= 1'b0;
    end
  end

  assign axi.arready = arready_ctl;
  assign axi.rvalid  = r_active && (!r_gap || r_tog);
  assign axi.rdata   = r_addr + {22'd0, r_cnt, 2'b00};
  assign axi.rlast   = r_active && (r_cnt == r_len);
  assign axi.rresp   = resp_val;
  assign axi.awready = 1'b1;
  assign axi.wready  = !w_gap || w_tog;
  assign axi.bvalid  = b_pend;
  assign axi.bresp   = resp_val;

  // Log of AR handshakes and accepted W beats. The log is kept across resets.
  int          ar_count = 0;
  int          w_count = 0;
  logic [31:0] w_log_data [0:63];
  logic        w_log_last [0:63];

  always @(posedge clk) begin
    if (axi.arvalid && axi.arready) ar_count <= ar_count + 1;
    if (axi.wvalid && axi.wready) begin
      w_log_data[w_count] <= axi.wdata;
      w_log_last[w_count] <= axi.wlast;
      w_count <= w_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic [7:0] il,
                               input logic dv, input logic [31:0] da, input logic [7:0] dl,
                               input logic wv, input logic [31:0] wa, input logic [7:0] wl);
    i_rvalid = iv; i_raddr = ia; i_rlen = il; i_rsize = SIZE_WORD;
    d_rvalid = dv; d_raddr = da; d_rlen = dl; d_rsize = SIZE_WORD;
    d_wvalid = wv; d_waddr = wa; d_wlen = wl; d_wsize = SIZE_WORD;
  endtask

  task automatic waitArValid(input string tag, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    while (!axi.arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_arvalid"}, 64'(axi.arvalid), 64'd1);
    if (axi.arvalid) begin
      checkOutput({tag, "_araddr"},  64'(axi.araddr),  64'(addr));
      checkOutput({tag, "_arlen"},   64'(axi.arlen),   64'(len));
      checkOutput({tag, "_arsize"},  64'(axi.arsize),  64'(SIZE_WORD));
      checkOutput({tag, "_arburst"}, 64'(axi.arburst), 64'(AXI_BURST_INCR));
    end
  endtask

  // Collect the beats of one read burst.
  // The task returns at the idle cycle that follows the last beat.
  task automatic collectRead(input string tag, input bit is_d, input logic [31:0] base,
                             input int len);
    int   k = 0;
    int   n = 0;
    logic own_rdy;
    logic own_last;
    logic oth_rdy;
    logic [31:0] own_data;
    while (k <= len && n < 60) begin
      @(negedge clk);
      n++;
      own_rdy  = is_d ? d_rready : i_rready;
      own_last = is_d ? d_rlast  : i_rlast;
      own_data = is_d ? d_rdata  : i_rdata;
      oth_rdy  = is_d ? i_rready : d_rready;
      checkOutput({tag, "_other_rready"}, 64'(oth_rdy), 64'd0);
      if (own_rdy) begin
        checkOutput({tag, "_rdata"}, 64'(own_data), 64'(base + 32'(k) * 32'd4));
        checkOutput({tag, "_rlast"}, 64'(own_last), 64'(k == len));
        k++;
      end
    end
    checkOutput({tag, "_beats"}, 64'(k), 64'(len + 1));
    @(negedge clk);
    checkOutput({tag, "_idle_rready"}, 64'(axi.rready), 64'd0);
    checkOutput({tag, "_idle_arvalid"}, 64'(axi.arvalid), 64'd0);
  endtask

  // Send one write-back burst from the first AW cycle through the B response pulse.
  task automatic doWrite(input string tag, input logic [31:0] base_data, input int len);
    int k = 0;
    int n = 0;
    while (k <= len && n < 80) begin
      d_wdata = base_data + 32'(k);
      d_wstrb = 4'hF;
      if (axi.wvalid && d_wready) begin
        checkOutput({tag, "_wlast"}, 64'(axi.wlast), 64'(k == len));
        k++;
      end
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_wbeats"}, 64'(k), 64'(len + 1));
    d_wvalid = 1'b0;
    checkOutput({tag, "_bvalid"}, 64'(d_bvalid), 64'd1);
    @(negedge clk);
    checkOutput({tag, "_bvalid_pulse"}, 64'(d_bvalid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ar0;
    int w0;
    int seen;
    int n;

    // reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_arvalid",  64'(axi.arvalid), 64'd0);
    checkOutput("rst_awvalid",  64'(axi.awvalid), 64'd0);
    checkOutput("rst_wvalid",   64'(axi.wvalid),  64'd0);
    checkOutput("rst_wlast",    64'(axi.wlast),   64'd0);
    checkOutput("rst_rready",   64'(axi.rready),  64'd0);
    checkOutput("rst_bready",   64'(axi.bready),  64'd0);
    checkOutput("rst_i_rready", 64'(i_rready),    64'd0);
    checkOutput("rst_d_rready", 64'(d_rready),    64'd0);
    checkOutput("rst_d_wready", 64'(d_wready),    64'd0);
    checkOutput("rst_d_bvalid", 64'(d_bvalid),    64'd0);
    checkOutput("rst_araddr",   64'(axi.araddr),  64'd0);
    checkOutput("rst_arlen",    64'(axi.arlen),   64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: icache only
    ar0 = ar_count;
    applyStimulus(1, 32'h100, 8'd3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_ar_latency", 64'(axi.arvalid), 64'd1);
    waitArValid("t1", 32'h100, 8'd3);
    i_rvalid = 1'b0;
    collectRead("t1", 1'b0, 32'h100, 3);
    checkOutput("t1_ar_count", 64'(ar_count - ar0), 64'd1);

    // 2: icache and dcache in the same cycle, dcache first
    applyStimulus(1, 32'h300, 8'd1, 1, 32'h200, 8'd1, 0, 0, 0);
    @(negedge clk);
    waitArValid("t2_d", 32'h200, 8'd1);
    d_rvalid = 1'b0;
    collectRead("t2_d", 1'b1, 32'h200, 1);
    @(negedge clk);
    checkOutput("t2_i_ar_latency", 64'(axi.arvalid), 64'd1);
    waitArValid("t2_i", 32'h300, 8'd1);
    i_rvalid = 1'b0;
    collectRead("t2_i", 1'b0, 32'h300, 1);

`ifdef ARB_PERF_CNT_EN
    checkOutput("t6_i_grant_cnt",  dut.i_grant_cnt,  64'd2);
    checkOutput("t6_d_rgrant_cnt", dut.d_rgrant_cnt, 64'd1);
    checkOutput("t6_d_wgrant_cnt", dut.d_wgrant_cnt, 64'd0);
    checkOutput("t6_wait_cnt_min", 64'(dut.wait_cnt >= 64'd4), 64'd1);
`endif

    // 3: write-back and refill together; the write goes first
    w0 = w_count;
    applyStimulus(0, 0, 0, 1, 32'h500, 8'd1, 1, 32'h400, 8'd3);
    @(negedge clk);
    checkOutput("t3_awvalid",  64'(axi.awvalid), 64'd1);
    checkOutput("t3_arvalid",  64'(axi.arvalid), 64'd0);
    checkOutput("t3_awaddr",   64'(axi.awaddr),  64'h400);
    checkOutput("t3_awlen",    64'(axi.awlen),   64'd3);
    checkOutput("t3_awburst",  64'(axi.awburst), 64'(AXI_BURST_INCR));
    doWrite("t3", 32'hA0, 3);
    @(negedge clk);
    checkOutput("t3_ar_after_b", 64'(axi.arvalid), 64'd1);
    waitArValid("t3_r", 32'h500, 8'd1);
    d_rvalid = 1'b0;
    collectRead("t3_r", 1'b1, 32'h500, 1);
    checkOutput("t3_wlog_count", 64'(w_count - w0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_wlog_data", 64'(w_log_data[w0 + k]), 64'(32'hA0 + 32'(k)));
      checkOutput("t3_wlog_last", 64'(w_log_last[w0 + k]), 64'(k == 3));
    end

    // 4: backpressure on AR, R and W, with error responses
    arready_ctl = 1'b0;
    r_gap = 1'b1;
    resp_val = 2'b10;
    ar0 = ar_count;
    applyStimulus(1, 32'h600, 8'd2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t4_arvalid_hold", 64'(axi.arvalid), 64'd1);
      checkOutput("t4_araddr_hold",  64'(axi.araddr),  64'h600);
      @(negedge clk);
    end
    arready_ctl = 1'b1;
    waitArValid("t4", 32'h600, 8'd2);
    i_rvalid = 1'b0;
    collectRead("t4", 1'b0, 32'h600, 2);
    checkOutput("t4_ar_count", 64'(ar_count - ar0), 64'd1);
    w_gap = 1'b1;
    w0 = w_count;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h700, 8'd2);
    @(negedge clk);
    checkOutput("t4_awvalid", 64'(axi.awvalid), 64'd1);
    doWrite("t4_w", 32'hB0, 2);
    checkOutput("t4_wlog_count", 64'(w_count - w0), 64'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4_wlog_data", 64'(w_log_data[w0 + k]), 64'(32'hB0 + 32'(k)));
    end
    r_gap = 1'b0;
    w_gap = 1'b0;
    resp_val = AXI_RESP_OKAY;
    @(negedge clk);

    // 5: reset during the second beat of an icache burst
    applyStimulus(1, 32'h800, 8'd3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    waitArValid("t5", 32'h800, 8'd3);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (i_rready) seen++;
    end
    checkOutput("t5_reached_beat2", 64'(seen), 64'd2);
    rstn = 1'b0;
    #1;
    checkOutput("t5_rst_i_rready", 64'(i_rready),    64'd0);
    checkOutput("t5_rst_i_rlast",  64'(i_rlast),     64'd0);
    checkOutput("t5_rst_rready",   64'(axi.rready),  64'd0);
    checkOutput("t5_rst_arvalid",  64'(axi.arvalid), 64'd0);
    checkOutput("t5_rst_araddr",   64'(axi.araddr),  64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("t5_restart_latency", 64'(axi.arvalid), 64'd1);
    waitArValid("t5_re", 32'h800, 8'd3);
    i_rvalid = 1'b0;
    collectRead("t5_re", 1'b0, 32'h800, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
